// File: rtl/lfsr10_pkg.sv
// Shared definitions for the 10-bit LFSR checker: widths, state encoding
// and the generator step function.
package lfsr10_pkg;

  localparam int LFSR_W = 10;
  localparam int ERR_W  = 16;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  // One generator clock: taps fold bit 0 back into bits 9, 8, 6 and 5.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n[9]   = s[0];
    n[8]   = s[9] ^ s[0];
    n[7]   = s[8];
    n[6]   = s[7] ^ s[0];
    n[5]   = s[6] ^ s[0];
    n[4:0] = s[5:1];
    return n;
  endfunction

endpackage

// File: rtl/lfsr10_step.sv
// Purely combinational LFSR advance, shared by checker and generator logic.
module lfsr10_step
  import lfsr10_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);

  assign nxt = lfsr_step(cur);

endmodule

// File: rtl/lfsr10_checker.sv
// Tracks a sampled 10-bit LFSR stream: seeds from a sample, confirms lock
// after LOCK_CNT correct predictions and counts mispredictions while locked.
module lfsr10_checker
  import lfsr10_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_word,
  input  logic              clr_count,
  output logic              locked,
  output logic              err_pulse,
  output logic              zero_err,
  output logic [ERR_W-1:0]  err_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_TGT = MW'(LOCK_CNT);
  localparam logic [LW-1:0] LOSS_TGT = LW'(LOSS_CNT);

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] pred, pred_nxt, word_step, pred_step;
  logic [MW-1:0]     match_cnt, match_nxt;
  logic [LW-1:0]     miss_cnt, miss_nxt;
  logic              err_ev, zero_ev;
  logic [ERR_W-1:0]  err_nxt;

  lfsr10_step u_word_step (.cur(in_word), .nxt(word_step));
  lfsr10_step u_pred_step (.cur(pred),    .nxt(pred_step));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_pulse <= 1'b0;
      zero_err  <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      pred      <= pred_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      err_pulse <= err_ev;
      zero_err  <= zero_ev;
      err_count <= err_nxt;
    end
  end

  // An all-zero sample is the LFSR lockup state and overrides every state.
  always_comb begin
    state_nxt = state;
    pred_nxt  = pred;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    err_ev    = 1'b0;
    zero_ev   = 1'b0;
    if (in_valid) begin
      if (in_word == '0) begin
        zero_ev   = 1'b1;
        state_nxt = SEARCH;
        match_nxt = '0;
        miss_nxt  = '0;
      end else begin
        unique case (state)
          SEARCH: begin
            pred_nxt  = word_step;
            match_nxt = '0;
            state_nxt = VERIFY;
          end
          VERIFY: begin
            pred_nxt = word_step;
            if (in_word == pred) begin
              match_nxt = match_cnt + 1'b1;
              if (match_nxt == LOCK_TGT) begin
                state_nxt = LOCKED;
                miss_nxt  = '0;
              end
            end else begin
              match_nxt = '0;
            end
          end
          LOCKED: begin
            if (in_word == pred) begin
              pred_nxt = word_step;
              miss_nxt = '0;
            end else begin
              // Flywheel: keep advancing our own prediction past the bad sample.
              err_ev   = 1'b1;
              pred_nxt = pred_step;
              miss_nxt = miss_cnt + 1'b1;
              if (miss_nxt == LOSS_TGT) begin
                state_nxt = SEARCH;
                miss_nxt  = '0;
              end
            end
          end
          default: state_nxt = SEARCH;
        endcase
      end
    end
  end

  always_comb begin
    err_nxt = err_count;
    if (clr_count) begin
      err_nxt = err_ev ? ERR_W'(1) : '0;
    end else if (err_ev && (err_count != '1)) begin
      err_nxt = err_count + 1'b1;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_lfsr10_checker.sv
// Randomized and directed bench for lfsr10_checker against a behavioural
// model of the lock / flywheel / error-count rules.
module tb_lfsr10_checker;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;
  localparam int HUNT = 0, CONFIRM = 1, TRACK = 2;

  logic        clk = 1'b0;
  logic        rst, in_valid, clr_count;
  logic [9:0]  in_word;
  logic        locked, err_pulse, zero_err;
  logic [15:0] err_count;

  logic        s_valid, s_clr;
  logic [9:0]  s_word;
  logic        s_locked, s_pulse, s_zero;
  logic [15:0] s_count;

  int total = 0;
  int bad   = 0;

  int mMode, mHits, mMisses, mPred, mErr;
  bit ePulse, eZero;
  int gen, sp, w, r;
  bit v, c;

  always #5 clk = ~clk;

  lfsr10_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
    .clr_count(clr_count), .locked(locked), .err_pulse(err_pulse),
    .zero_err(zero_err), .err_count(err_count)
  );

  // Long-tolerance instance used only to reach counter saturation quickly.
  lfsr10_checker #(.LOCK_CNT(LOCK_N), .LOSS_CNT(70000)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_word(s_word),
    .clr_count(s_clr), .locked(s_locked), .err_pulse(s_pulse),
    .zero_err(s_zero), .err_count(s_count)
  );

  // Galois form: shift right, fold the dropped bit into the tap mask.
  function automatic int stepRef(input int s);
    return (s >> 1) ^ (((s & 1) != 0) ? 'h360 : 0);
  endfunction

  function automatic int corruptOf(input int p);
    int x;
    x = p ^ 'h155;
    if (x == 0) x = 'h2AA;
    return x & 'h3FF;
  endfunction

  task automatic modelReset();
    mMode = HUNT; mHits = 0; mMisses = 0; mPred = 0; mErr = 0;
    ePulse = 1'b0; eZero = 1'b0;
  endtask

  task automatic modelStep(input bit vv, input int ww, input bit cc);
    ePulse = 1'b0;
    eZero  = 1'b0;
    if (vv) begin
      if (ww == 0) begin
        eZero = 1'b1; mMode = HUNT; mHits = 0; mMisses = 0;
      end else if (mMode == HUNT) begin
        mPred = stepRef(ww); mHits = 0; mMode = CONFIRM;
      end else if (mMode == CONFIRM) begin
        if (ww == mPred) begin
          mHits++;
          if (mHits == LOCK_N) begin mMode = TRACK; mMisses = 0; end
        end else begin
          mHits = 0;
        end
        mPred = stepRef(ww);
      end else begin
        if (ww == mPred) begin
          mMisses = 0; mPred = stepRef(ww);
        end else begin
          ePulse = 1'b1; mPred = stepRef(mPred); mMisses++;
          if (mMisses == LOSS_N) begin mMode = HUNT; mMisses = 0; end
        end
      end
    end
    if (cc) mErr = ePulse ? 1 : 0;
    else if (ePulse && mErr < 65535) mErr++;
  endtask

  task automatic checkFlag(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkFlag("locked",    {31'd0, locked},    (mMode == TRACK) ? 32'd1 : 32'd0);
    checkFlag("err_pulse", {31'd0, err_pulse}, {31'd0, ePulse});
    checkFlag("zero_err",  {31'd0, zero_err},  {31'd0, eZero});
    checkFlag("err_count", {16'd0, err_count}, mErr);
  endtask

  task automatic applyStimulus(input bit vv, input int ww, input bit cc);
    in_valid  = vv;
    in_word   = ww[9:0];
    clr_count = cc;
    @(posedge clk);
    modelStep(vv, ww, cc);
    #1;
    checkOutput();
  endtask

  task automatic feedTrue(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, gen, 1'b0);
      gen = stepRef(gen);
    end
  endtask

  task automatic feedBad(input bit cc);
    applyStimulus(1'b1, corruptOf(gen), cc);
    gen = stepRef(gen);
  endtask

  task automatic doReset();
    rst = 1'b1; in_valid = 1'b0; clr_count = 1'b0;
    s_valid = 1'b0; s_clr = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic satStep(input int ww, input bit cc);
    s_valid = 1'b1;
    s_word  = ww[9:0];
    s_clr   = cc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_word = '0; clr_count = 1'b0;
    s_valid = 1'b0; s_word = '0; s_clr = 1'b0;
    #2;
    doReset();

    // Seed plus four matches locks on the fifth word.
    gen = 1;
    feedTrue(4);
    checkFlag("no_lock_after4", {31'd0, locked}, 32'd0);
    feedTrue(1);
    checkFlag("lock_after5", {31'd0, locked}, 32'd1);

    // One corrupt word while locked.
    feedTrue(2);
    w = (gen == 'h155) ? corruptOf(gen) : 'h155;
    applyStimulus(1'b1, w, 1'b0);
    gen = stepRef(gen);
    checkFlag("single_err_pulse", {31'd0, err_pulse}, 32'd1);
    checkFlag("single_err_count", {16'd0, err_count}, 32'd1);
    checkFlag("single_keeps_lock", {31'd0, locked}, 32'd1);
    feedTrue(1);
    checkFlag("pulse_one_cycle", {31'd0, err_pulse}, 32'd0);
    checkFlag("flywheel_count", {16'd0, err_count}, 32'd1);

    // Clear alone, then three misses drop lock, then relock.
    applyStimulus(1'b1, gen, 1'b1);
    gen = stepRef(gen);
    checkFlag("clr_alone", {16'd0, err_count}, 32'd0);
    feedBad(1'b0); feedBad(1'b0);
    checkFlag("two_miss_lock", {31'd0, locked}, 32'd1);
    feedBad(1'b0);
    checkFlag("loss_count", {16'd0, err_count}, 32'd3);
    checkFlag("loss_unlock", {31'd0, locked}, 32'd0);
    feedTrue(4);
    checkFlag("relock_early", {31'd0, locked}, 32'd0);
    feedTrue(1);
    checkFlag("relock", {31'd0, locked}, 32'd1);

    // Zero word in LOCKED, VERIFY and SEARCH.
    applyStimulus(1'b1, 0, 1'b0);
    gen = stepRef(gen);
    checkFlag("zero_locked_flag", {31'd0, zero_err}, 32'd1);
    checkFlag("zero_locked_unlock", {31'd0, locked}, 32'd0);
    checkFlag("zero_keeps_count", {16'd0, err_count}, 32'd3);
    applyStimulus(1'b0, 0, 1'b0);
    checkFlag("zero_one_cycle", {31'd0, zero_err}, 32'd0);
    feedTrue(2);
    applyStimulus(1'b1, 0, 1'b0);
    gen = stepRef(gen);
    checkFlag("zero_verify", {31'd0, zero_err}, 32'd1);
    applyStimulus(1'b1, 0, 1'b0);
    gen = stepRef(gen);
    checkFlag("zero_search", {31'd0, zero_err}, 32'd1);

    // Alternating valid/idle gives the same lock timing in valid words.
    doReset();
    gen = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, gen, 1'b0);
      gen = stepRef(gen);
      if (i == 3) checkFlag("toggle_no_lock", {31'd0, locked}, 32'd0);
      applyStimulus(1'b0, $urandom_range(0, 1023), 1'b0);
    end
    checkFlag("toggle_lock", {31'd0, locked}, 32'd1);

    // Clear coincident with an error.
    feedBad(1'b1);
    checkFlag("clr_with_err", {16'd0, err_count}, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      v = ($urandom_range(0, 9) < 7);
      c = v && ($urandom_range(0, 19) == 0);
      if (!v) begin
        applyStimulus(1'b0, $urandom_range(0, 1023), 1'b0);
      end else if (r < 3) begin
        feedBad(c); feedBad(1'b0); feedBad(1'b0);
      end else if (r < 10) begin
        feedBad(c);
      end else if (r < 13) begin
        applyStimulus(1'b1, 0, c);
        gen = stepRef(gen);
      end else begin
        applyStimulus(1'b1, gen, c);
        gen = stepRef(gen);
      end
    end

    // Asynchronous reset in the middle of a lock.
    feedTrue(LOCK_N + 1);
    checkFlag("pre_reset_lock", {31'd0, locked}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkFlag("rst_locked", {31'd0, locked}, 32'd0);
    checkFlag("rst_count", {16'd0, err_count}, 32'd0);
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    gen = stepRef(gen);
    feedTrue(4);
    checkFlag("rst_needs_reseed", {31'd0, locked}, 32'd0);
    feedTrue(1);
    checkFlag("rst_relock", {31'd0, locked}, 32'd1);

    // Saturation on the long-tolerance instance.
    doReset();
    sp = 1;
    for (int i = 0; i < 5; i++) begin
      satStep(sp, 1'b0);
      sp = stepRef(sp);
    end
    checkFlag("sat_lock", {31'd0, s_locked}, 32'd1);
    for (int i = 0; i < 65535; i++) begin
      satStep(corruptOf(sp), 1'b0);
      sp = stepRef(sp);
    end
    checkFlag("sat_full", {16'd0, s_count}, 32'hFFFF);
    satStep(corruptOf(sp), 1'b0);
    sp = stepRef(sp);
    checkFlag("sat_hold", {16'd0, s_count}, 32'hFFFF);
    checkFlag("sat_pulse", {31'd0, s_pulse}, 32'd1);
    satStep(corruptOf(sp), 1'b1);
    sp = stepRef(sp);
    checkFlag("sat_clr_err", {16'd0, s_count}, 32'd1);
    satStep(sp, 1'b1);
    sp = stepRef(sp);
    checkFlag("sat_clr_alone", {16'd0, s_count}, 32'd0);
    s_valid = 1'b0;
    s_clr   = 1'b0;
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
